// File: rtl/mult_requester.sv
// mult_requester: initiator for the signed parity-protected multiplier
// req/ack protocol. It accepts one operand pair at a time on a valid/ready
// command port and drives req/arg_* toward the responder. It then waits for
// ack and result_rdy, checks the returned result parity, and presents one
// response word per command on a valid/ready response port.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready is a state decode)
//   cmd_a, cmd_b, cmd_inject       signed operands, parity-inversion request
//   rsp_valid/rsp_ready            response handshake
//   rsp_result, rsp_arg_err,
//   rsp_res_perr, rsp_timeout      response payload and status flags
//   arg_a, arg_b, arg_*_parity,
//   req                            request side toward the responder
//   ack, result, result_parity,
//   result_rdy, arg_parity_error   responder return path
module mult_requester #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_W-1:0]     cmd_a,
    input  logic [DATA_W-1:0]     cmd_b,
    input  logic [1:0]            cmd_inject,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_result,
    output logic                  rsp_arg_err,
    output logic                  rsp_res_perr,
    output logic                  rsp_timeout,
    output logic [DATA_W-1:0]     arg_a,
    output logic [DATA_W-1:0]     arg_b,
    output logic                  arg_a_parity,
    output logic                  arg_b_parity,
    output logic                  req,
    input  logic                  ack,
    input  logic [2*DATA_W-1:0]   result,
    input  logic                  result_parity,
    input  logic                  result_rdy,
    input  logic                  arg_parity_error
);

    localparam int unsigned RES_W = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REQ      = 2'd1;
    localparam logic [1:0] S_WAIT_RDY = 2'd2;
    localparam logic [1:0] S_RSP      = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;
    logic              r_req;
    logic [DATA_W-1:0] r_arg_a;
    logic [DATA_W-1:0] r_arg_b;
    logic              r_arg_a_par;
    logic              r_arg_b_par;
    logic              r_rsp_valid;
    logic [RES_W-1:0]  r_rsp_result;
    logic              r_rsp_arg_err;
    logic              r_rsp_res_perr;
    logic              r_rsp_timeout;

    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_req_nxt;
    logic [DATA_W-1:0] w_arg_a_nxt;
    logic [DATA_W-1:0] w_arg_b_nxt;
    logic              w_arg_a_par_nxt;
    logic              w_arg_b_par_nxt;
    logic              w_rsp_valid_nxt;
    logic [RES_W-1:0]  w_rsp_result_nxt;
    logic              w_rsp_arg_err_nxt;
    logic              w_rsp_res_perr_nxt;
    logic              w_rsp_timeout_nxt;
    logic              w_limit;
    logic              w_capture;
    logic              w_abort;

    // r_run keeps cmd_ready low while reset is held and until the first edge after release
    assign cmd_ready = r_run && (r_state == S_IDLE);

    assign req          = r_req;
    assign arg_a        = r_arg_a;
    assign arg_b        = r_arg_b;
    assign arg_a_parity = r_arg_a_par;
    assign arg_b_parity = r_arg_b_par;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_arg_err  = r_rsp_arg_err;
    assign rsp_res_perr = r_rsp_res_perr;
    assign rsp_timeout  = r_rsp_timeout;

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_req_nxt          = r_req;
        w_arg_a_nxt        = r_arg_a;
        w_arg_b_nxt        = r_arg_b;
        w_arg_a_par_nxt    = r_arg_a_par;
        w_arg_b_par_nxt    = r_arg_b_par;
        w_rsp_valid_nxt    = r_rsp_valid;
        w_rsp_result_nxt   = r_rsp_result;
        w_rsp_arg_err_nxt  = r_rsp_arg_err;
        w_rsp_res_perr_nxt = r_rsp_res_perr;
        w_rsp_timeout_nxt  = r_rsp_timeout;
        w_capture          = 1'b0;
        w_abort            = 1'b0;
        // Counter holds the number of waiting edges already spent; this edge is the last allowed
        w_limit            = (r_cnt >= CNT_W'(TIMEOUT - 1));

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_arg_a_nxt     = cmd_a;
                    w_arg_b_nxt     = cmd_b;
                    w_arg_a_par_nxt = (^cmd_a) ^ cmd_inject[0];
                    w_arg_b_par_nxt = (^cmd_b) ^ cmd_inject[1];
                    w_cnt_nxt       = '0;
                    w_req_nxt       = 1'b1;
                    w_state_nxt     = S_REQ;
                end
            end
            S_REQ: begin
                // result_rdy alone implies the ack; events beat the timeout on the same edge
                if (result_rdy) begin
                    w_capture = 1'b1;
                end else if (ack) begin
                    w_req_nxt   = 1'b0;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = S_WAIT_RDY;
                end else if (w_limit) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_RDY: begin
                if (result_rdy) begin
                    w_capture = 1'b1;
                end else if (w_limit) begin
                    w_abort = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Result parity is meaningless when the responder rejected the operands
        if (w_capture) begin
            w_req_nxt          = 1'b0;
            w_rsp_valid_nxt    = 1'b1;
            w_rsp_result_nxt   = result;
            w_rsp_arg_err_nxt  = arg_parity_error;
            w_rsp_res_perr_nxt = ((^result) != result_parity) && !arg_parity_error;
            w_rsp_timeout_nxt  = 1'b0;
            w_state_nxt        = S_RSP;
        end

        if (w_abort) begin
            w_req_nxt          = 1'b0;
            w_rsp_valid_nxt    = 1'b1;
            w_rsp_result_nxt   = '0;
            w_rsp_arg_err_nxt  = 1'b0;
            w_rsp_res_perr_nxt = 1'b0;
            w_rsp_timeout_nxt  = 1'b1;
            w_state_nxt        = S_RSP;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_run          <= 1'b0;
            r_req          <= 1'b0;
            r_arg_a        <= '0;
            r_arg_b        <= '0;
            r_arg_a_par    <= 1'b0;
            r_arg_b_par    <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_arg_err  <= 1'b0;
            r_rsp_res_perr <= 1'b0;
            r_rsp_timeout  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_run          <= 1'b1;
            r_req          <= w_req_nxt;
            r_arg_a        <= w_arg_a_nxt;
            r_arg_b        <= w_arg_b_nxt;
            r_arg_a_par    <= w_arg_a_par_nxt;
            r_arg_b_par    <= w_arg_b_par_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_rsp_result   <= w_rsp_result_nxt;
            r_rsp_arg_err  <= w_rsp_arg_err_nxt;
            r_rsp_res_perr <= w_rsp_res_perr_nxt;
            r_rsp_timeout  <= w_rsp_timeout_nxt;
        end
    end

endmodule
